// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between core datapath (master) and memory responder (slave).
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 word RAM, synchronous write and registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IW    = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder; DMEM_ERR_EN enables misalign/range faults.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic                clk,
  input logic                rst_n,
  data_mem_responder_if.slave bus
);

  localparam int IW = idx_w(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic              r_fault;
  logic [IW-1:0]     r_idx;
  logic [WORD_W-1:0] r_wdata;

  logic              w_idle;
  logic              w_acc;
  logic              w_go;
  logic              w_fault_in;
  logic              w_we;
  logic              w_fault;
  logic [IW-1:0]     w_idx;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rdata;

  assign w_idle = (r_state == IDLE);
  assign w_acc  = w_idle && bus.req_valid;

`ifdef DMEM_ERR_EN
  assign w_fault_in = (bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_addr[31:2] >= 30'(DEPTH));
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.req_addr[1:0],
                           bus.req_addr[WORD_W-1:IW+2]};
  assign w_fault_in = 1'b0;
`endif

  // With LATENCY==1 the RAM is touched on the accept edge itself,
  // before the capture registers hold the request.
  assign w_we    = w_idle ? bus.req_we : r_we;
  assign w_fault = w_idle ? w_fault_in : r_fault;
  assign w_idx   = w_idle ? bus.req_addr[IW+1:2] : r_idx;
  assign w_wdata = w_idle ? bus.req_wdata : r_wdata;

  assign w_go = (w_acc && (LATENCY == 1)) ||
                ((r_state == WAIT) && (r_cnt == CNT_ONE));

  dmem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_go && w_we && !w_fault),
    .i_re    (w_go && !w_we && !w_fault),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_fault <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_we    <= bus.req_we;
            r_fault <= w_fault_in;
            r_idx   <= bus.req_addr[IW+1:2];
            r_wdata <= bus.req_wdata;
            r_cnt   <= CNT_INIT;
            r_state <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read register is masked so data reads 0 outside a load response.
  assign bus.req_ready  = w_idle;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = (bus.resp_valid && !r_we && !r_fault) ?
                          w_rdata : '0;
  assign bus.resp_err   = bus.resp_valid && r_fault;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=2 and LATENCY=1.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  data_mem_responder_if b2 ();
  data_mem_responder_if b1 ();

  data_mem_responder #(
    .DEPTH   (256),
    .LATENCY (2)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  data_mem_responder #(
    .DEPTH   (256),
    .LATENCY (1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn2(input string tag,
                      input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [31:0] exp_rd,
                      input logic exp_err,
                      input int hold);
    int n;
    @(negedge clk);
    chk({tag, ".rdy"}, b2.req_ready, 1);
    b2.req_valid  = 1'b1;
    b2.req_we     = we;
    b2.req_addr   = addr;
    b2.req_wdata  = wdata;
    b2.resp_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      b2.req_valid = 1'b0;
      n++;
    end while (!b2.resp_valid && n < 20);
    chk({tag, ".lat"}, 32'(n), 32'd2);
    chk({tag, ".rdata"}, b2.resp_rdata, exp_rd);
    chk({tag, ".err"}, b2.resp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_v"}, b2.resp_valid, 1);
      chk({tag, ".hold_d"}, b2.resp_rdata, exp_rd);
      chk({tag, ".hold_r"}, b2.req_ready, 0);
    end
    b2.resp_ready = 1'b1;
    @(negedge clk);
    b2.resp_ready = 1'b0;
    chk({tag, ".idle_r"}, b2.req_ready, 1);
    chk({tag, ".idle_v"}, b2.resp_valid, 0);
    chk({tag, ".idle_d"}, b2.resp_rdata, 0);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".b2rdy"}, b2.req_ready, 1);
    chk({tag, ".b2val"}, b2.resp_valid, 0);
    chk({tag, ".b2dat"}, b2.resp_rdata, 0);
    chk({tag, ".b2err"}, b2.resp_err, 0);
    chk({tag, ".b1rdy"}, b1.req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst_n         = 1'b1;
    b2.req_valid  = 1'b0;
    b2.req_we     = 1'b0;
    b2.req_addr   = '0;
    b2.req_wdata  = '0;
    b2.resp_ready = 1'b0;
    b1.req_valid  = 1'b0;
    b1.req_we     = 1'b0;
    b1.req_addr   = '0;
    b1.req_wdata  = '0;
    b1.resp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_rst("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    txn2("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    txn2("lw10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    txn2("bp",   1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    // reset while a load response is pending
    @(negedge clk);
    b2.req_valid  = 1'b1;
    b2.req_we     = 1'b0;
    b2.req_addr   = 32'h10;
    b2.resp_ready = 1'b0;
    @(negedge clk);
    b2.req_valid = 1'b0;
    chk("mid.wait_v", b2.resp_valid, 0);
    @(negedge clk);
    chk("mid.resp_v", b2.resp_valid, 1);
    chk("mid.resp_d", b2.resp_rdata, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1 chk_rst("rst_resp");
    @(negedge clk);
    rst_n = 1'b1;

    txn2("sw20", 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    @(negedge clk);
    b2.req_valid = 1'b1;
    b2.req_we    = 1'b1;
    b2.req_addr  = 32'h20;
    b2.req_wdata = 32'h12345678;
    @(negedge clk);
    b2.req_valid = 1'b0;
    chk("abort.wait", b2.req_ready, 0);
    #2 rst_n = 1'b0;
    #1 chk_rst("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    b2.resp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort.noresp", b2.resp_valid, 0);
    end
    b2.resp_ready = 1'b0;
    txn2("lw20", 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    // LATENCY=1 stream: 4 stores then 4 loads, req_valid held high
    b1.resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 32'hC0DE0000 | 32'(i % 4);
      @(negedge clk);
      chk("l1.rdy", b1.req_ready, 1);
      b1.req_valid = 1'b1;
      b1.req_we    = (i < 4);
      b1.req_addr  = 32'h40 + 32'(4 * (i % 4));
      b1.req_wdata = d;
      @(negedge clk);
      chk("l1.val", b1.resp_valid, 1);
      chk("l1.busy", b1.req_ready, 0);
      chk("l1.data", b1.resp_rdata, (i < 4) ? 32'h0 : d);
    end
    b1.req_valid = 1'b0;

    txn2("sw0", 1'b1, 32'h0, 32'h0BADF00D, 32'h0, 1'b0, 0);
`ifdef DMEM_ERR_EN
    txn2("lw400", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 0);
    txn2("sw02", 1'b1, 32'h02, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    txn2("lw0", 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 0);
`else
    txn2("lw400", 1'b0, 32'h400, 32'h0, 32'h0BADF00D, 1'b0, 0);
    txn2("sw02", 1'b1, 32'h02, 32'hFFFFFFFF, 32'h0, 1'b0, 0);
    txn2("lw0", 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
